// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat game controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_t FSM encoding, card code constants, score thresholds,
// card_value() helper mapping a card code to its baccarat point value.
package baccarat_pkg;

  typedef enum logic [3:0] {
    START   = 4'd0,
    DEAL_P1 = 4'd1,
    DEAL_D1 = 4'd2,
    DEAL_P2 = 4'd3,
    DEAL_D2 = 4'd4,
    CHECK   = 4'd5,
    DEAL_P3 = 4'd6,
    CHECK_D = 4'd7,
    DEAL_D3 = 4'd8,
    DONE    = 4'd9
  } state_t;

  // Card codes as presented by the datapath
  localparam logic [3:0] CARD_NONE = 4'd0;
  localparam logic [3:0] CARD_ACE  = 4'd1;
  localparam logic [3:0] CARD_TEN  = 4'd10;
  localparam logic [3:0] CARD_KING = 4'd13;

  // Score thresholds
  localparam logic [3:0] NATURAL_MIN     = 4'd8;
  localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;
  localparam logic [3:0] DEALER_DRAW_MAX = 4'd5;

  // Ten and face cards count zero. "No card" is code 0, which already
  // yields zero, so an absent third card naturally reads as value 0.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    if (code >= CARD_TEN && code <= CARD_KING) begin
      return 4'd0;
    end
    return code;
  endfunction

endpackage

// File: rtl/banker_draw.sv
// Banker third-card rule: decides whether the dealer draws given his score
// and the player's third card. Latency: purely combinational.
// Backpressure: none.
// Ports: dscore (dealer score 0..9), pcard3 (player third card code),
//        draw (1 = dealer takes a third card).
module banker_draw
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  logic [3:0] v;

  assign v = card_value(pcard3);

  always_comb begin
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;  // 7..9 stand; >9 is illegal, stand
    endcase
  end

endmodule

// File: rtl/baccarat_fsm.sv
// Baccarat game controller: sequences card loads and applies drawing rules.
// Latency: DONE 6/7/8/9 slow_clock edges after reset release (stand/dealer/player/both draw).
// Backpressure: none; free-running once reset is released, halts in DONE.
// Ports: slow_clock, resetb (async active-low); pcard3/pscore/dscore from the
//        datapath; load_{p,d}card{1,2,3} one-hot load strobes; two win lights.
module baccarat_fsm
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pcard3,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
);

  state_t state;
  state_t state_nxt;
  logic   dealer_draw;

  banker_draw u_banker_draw (
    .dscore (dscore),
    .pcard3 (pcard3),
    .draw   (dealer_draw)
  );

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state <= START;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      START:   state_nxt = DEAL_P1;
      DEAL_P1: state_nxt = DEAL_D1;
      DEAL_D1: state_nxt = DEAL_P2;
      DEAL_P2: state_nxt = DEAL_D2;
      DEAL_D2: state_nxt = CHECK;
      CHECK: begin
        // Scores above 9 are illegal and fall into the natural branch.
        if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN) begin
          state_nxt = DONE;
        end else if (pscore <= PLAYER_DRAW_MAX) begin
          state_nxt = DEAL_P3;
        end else if (dscore <= DEALER_DRAW_MAX) begin
          // Player stood on 6/7: dealer draws on the simple rule only.
          state_nxt = DEAL_D3;
        end else begin
          state_nxt = DONE;
        end
      end
      DEAL_P3: state_nxt = CHECK_D;
      CHECK_D: state_nxt = dealer_draw ? DEAL_D3 : DONE;
      DEAL_D3: state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = START;
    endcase
  end

  // Moore strobes: the datapath captures on the edge that leaves the state.
  assign load_pcard1 = (state == DEAL_P1);
  assign load_dcard1 = (state == DEAL_D1);
  assign load_pcard2 = (state == DEAL_P2);
  assign load_dcard2 = (state == DEAL_D2);
  assign load_pcard3 = (state == DEAL_P3);
  assign load_dcard3 = (state == DEAL_D3);

  // A tie lights both.
  assign player_win_light = (state == DONE) && (pscore >= dscore);
  assign dealer_win_light = (state == DONE) && (dscore >= pscore);

endmodule

// File: doc/baccarat_fsm.md
Name: baccarat_fsm

Overview:
- Control state machine for the baccarat game, sitting directly beside the card/score datapath.
- Sequences the load strobes for the six card registers in deal order.
- Consumes the datapath's player score, dealer score and player third card to apply the baccarat drawing rules.
- Drives the two win lights once the hand is complete.

Parameters:
none

Ports:
- slow_clock  input  1  game clock; all state changes occur on its rising edge
- resetb  input  1  asynchronous, active-low reset
- pcard3  input  4  player third card code: 0=none, 1=Ace, 2..10, 11=J, 12=Q, 13=K
- pscore  input  4  player hand score, 0..9, combinational from the datapath
- dscore  input  4  dealer hand score, 0..9, combinational from the datapath
- load_pcard1, load_pcard2, load_pcard3  output  1 each  player card register load strobes
- load_dcard1, load_dcard2, load_dcard3  output  1 each  dealer card register load strobes
- player_win_light  output  1  player wins, or tie
- dealer_win_light  output  1  dealer wins, or tie

Behaviour:
- Reset: single clock slow_clock; resetb is asynchronous and active-low. Asserting resetb forces state START immediately, independent of the clock. All outputs are 0 in START.
- Outputs are Moore, decoded from the state only (lights also use the scores). At most one load strobe is high in any cycle. The datapath captures the card on the rising edge that ends the strobe state; scores reflect that card in the following cycle.
- States and transitions (one slow_clock edge each unless stated):
  - START -> DEAL_P1 -> DEAL_D1 -> DEAL_P2 -> DEAL_D2 -> CHECK.
  - Strobes: DEAL_P1 asserts load_pcard1, DEAL_D1 load_dcard1, DEAL_P2 load_pcard2, DEAL_D2 load_dcard2.
  - CHECK, evaluated in priority order:
    - pscore>=8 or dscore>=8 (natural) -> DONE.
    - Else pscore<=5 -> DEAL_P3.
    - Else dscore<=5 -> DEAL_D3.
    - Else -> DONE.
  - DEAL_P3 asserts load_pcard3 -> CHECK_D.
  - CHECK_D applies the banker rule -> DEAL_D3 if draw, else DONE.
  - DEAL_D3 asserts load_dcard3 -> DONE.
  - DONE holds until resetb is asserted; there is no self-restart.
- Banker rule (CHECK_D only). Let v = value of pcard3, where codes 10..13 give v=0 and other codes give v=code. Dealer draws when:
  - dscore 0..2: always.
  - dscore 3: v!=8.
  - dscore 4: v in 2..7.
  - dscore 5: v in 4..7.
  - dscore 6: v in 6..7.
  - dscore 7..9: never.
- Win lights, high only in DONE:
  - pscore>dscore: player light only.
  - dscore>pscore: dealer light only.
  - Equal: both lights.
  - Both are 0 in every other state.
- Latency from reset release:
  - Natural or both stand: DONE after 6 edges.
  - Dealer-only draw: DONE after 7 edges.
  - Player draws, dealer stands: DONE after 8 edges.
  - Both draw: DONE after 9 edges.
- Boundaries:
  - Scores >9 are illegal inputs and are treated as >=8 in CHECK.
  - pcard3 = 0 in CHECK_D is an illegal input and is treated as v=0.
  - Reset mid-deal aborts immediately: strobes drop the same instant and the deal restarts from START.
  - Input changes outside CHECK, CHECK_D and DONE have no effect.

Decomposition:
- baccarat_pkg:
  - state_t enum (START, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, CHECK, DEAL_P3, CHECK_D, DEAL_D3, DONE).
  - Card code constants (CARD_NONE=0, CARD_ACE=1, CARD_TEN=10, CARD_KING=13).
  - NATURAL_MIN=8, PLAYER_DRAW_MAX=5.
- One combinational sub-module, banker_draw: inputs dscore and pcard3, output draw.

Test Plan:
- Natural:
  - Stimulus: reset, then step while driving pscore=8 and dscore=3 from CHECK.
  - Response: strobes pulse P1, D1, P2, D2 on edges 2-5. DONE at edge 6 with player_win_light=1 and dealer_win_light=0. load_pcard3 and load_dcard3 are never high.
- Player draw, dealer draws:
  - Stimulus: pscore=4 and dscore=4 in CHECK, then pcard3=2 in CHECK_D.
  - Response: DEAL_P3 then DEAL_D3. With final pscore=6 and dscore=7, dealer_win_light=1 only.
- Dealer stands on 3 versus an 8:
  - Stimulus: pscore=2 and dscore=3 in CHECK, then pcard3=8 in CHECK_D.
  - Response: load_dcard3 is never asserted. DONE at edge 8.
- Player stands, dealer draws on 5:
  - Stimulus: pscore=7 and dscore=5 in CHECK.
  - Response: DEAL_D3 directly with no load_pcard3. DONE at edge 7.
- Tie:
  - Stimulus: pscore=6 and dscore=6 in CHECK.
  - Response: both stand, DONE at edge 6, both lights=1.
- Mid-deal reset:
  - Stimulus: assert resetb low while in DEAL_P2, between clock edges.
  - Response: load_pcard2 drops immediately. After release, the sequence restarts with load_pcard1 on the second edge.
